// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control decoder.
// Opcode map, branch condition codes, flag bit positions, the registered
// control bundle with its bubble value, and the issue FSM state encoding.
package ctrl_pkg;

  // Base 4-bit opcode map (upper opcode bits, when present, must be zero)
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_RL   = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_EXEC = 4'hF;

  // Branch condition codes
  localparam logic [2:0] CC_EQ = 3'd0;
  localparam logic [2:0] CC_NE = 3'd1;
  localparam logic [2:0] CC_GT = 3'd2;
  localparam logic [2:0] CC_LT = 3'd3;
  localparam logic [2:0] CC_GE = 3'd4;
  localparam logic [2:0] CC_LE = 3'd5;
  localparam logic [2:0] CC_OV = 3'd6;
  localparam logic [2:0] CC_AL = 3'd7;

  // Flag register bit positions: {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Single-bit control outputs; alu_op is carried separately (ALUW wide)
  typedef struct packed {
    logic dmem_wen;      // active low
    logic rf_wen;
    logic alusrc;
    logic regdest;
    logic branch;
    logic branch_taken;
    logic mem2reg;
    logic lhb_llb_con1;
    logic s5;
    logic s6;
    logic s7;
    logic jal;
    logic jr;
    logic exec;
    logic lw;
    logic illegal;
  } ctrl_bundle_t;

  // Bundle that does nothing: memory write disabled, everything else low
  localparam ctrl_bundle_t CTRL_BUBBLE = '{dmem_wen: 1'b1, default: 1'b0};

  // Issue FSM: RUN accepts instructions, EXEC_HOLD inserts bubbles
  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_EXEC_HOLD = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch condition resolver.
// Maps a condition code and the {Z,V,N} flags to a taken/not-taken bit.
module br_cond_eval
  import ctrl_pkg::*;
#(
  parameter int CONDW = 3
) (
  input  logic [CONDW-1:0] i_cond,
  input  logic [2:0]       i_flags,
  output logic             o_taken
);

  logic [2:0] w_cc;
  logic       w_z;
  logic       w_v;
  logic       w_n;

  assign w_cc = 3'(i_cond);
  assign w_z  = i_flags[FLAG_Z];
  assign w_v  = i_flags[FLAG_V];
  assign w_n  = i_flags[FLAG_N];

  // Resolve the selected condition against the flags
  always_comb begin
    o_taken = 1'b0;
    case (w_cc)
      CC_EQ:   o_taken = w_z;
      CC_NE:   o_taken = !w_z;
      CC_GT:   o_taken = !w_z && !w_n;
      CC_LT:   o_taken = w_n;
      CC_GE:   o_taken = w_z || !w_n;
      CC_LE:   o_taken = w_z || w_n;
      CC_OV:   o_taken = w_v;
      CC_AL:   o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered control decoder with flag register,
// in-block branch resolution and an EXEC issue-bubble FSM.
// Optional build macro CTRL_FLAG_BYPASS_EN: when defined, branch conditions
// see flag_in in the same cycle flag_wen is high; otherwise they see only
// the registered flags.
//
// Handshake: an instruction is transferred on a cycle where in_valid and
// in_ready are both high; in_ready does not depend on in_valid. The bundle
// for a transferred instruction is presented the next cycle with
// out_valid=1. Downstream does not backpressure; stall/flush from the
// hazard unit hold or clear the output register instead.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int CONDW        = 3,
  parameter int ALUW         = 3,
  parameter int EXEC_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [CONDW-1:0] cond,
  input  logic [2:0]       flag_in,
  input  logic             flag_wen,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             dmem_wen,
  output logic             rf_wen,
  output logic             alusrc,
  output logic             regdest,
  output logic             branch,
  output logic             branch_taken,
  output logic             mem2reg,
  output logic             lhb_llb_con1,
  output logic             s5,
  output logic             s6,
  output logic             s7,
  output logic             jal,
  output logic             jr,
  output logic             exec,
  output logic             lw,
  output logic [ALUW-1:0]  alu_op,
  output logic             illegal,
  output logic             o_dbg_state
);

  ctrl_state_e   r_state;
  ctrl_state_e   w_state_n;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_n;
  logic [2:0]    r_flags;
  logic [2:0]    w_flags_eval;
  ctrl_bundle_t  r_bundle;
  ctrl_bundle_t  w_dec;
  logic [ALUW-1:0] r_alu;
  logic [ALUW-1:0] w_alu;
  logic          r_out_valid;
  logic [3:0]    w_op4;
  logic          w_upper_nz;
  logic          w_is_exec;
  logic          w_accept;
  logic          w_taken;

  assign w_op4      = opcode[3:0];
  assign w_upper_nz = |(opcode >> 4);
  assign w_is_exec  = !w_upper_nz && (w_op4 == OP_EXEC);
  assign in_ready   = !rst && !stall && (r_state == ST_RUN);
  assign w_accept   = in_valid && in_ready;

`ifdef CTRL_FLAG_BYPASS_EN
  assign w_flags_eval = flag_wen ? flag_in : r_flags;
`else
  assign w_flags_eval = r_flags;
`endif

  br_cond_eval #(.CONDW(CONDW)) u_br_cond_eval (
    .i_cond  (cond),
    .i_flags (w_flags_eval),
    .o_taken (w_taken)
  );

  // Decode the presented opcode into a control bundle
  always_comb begin
    w_dec = CTRL_BUBBLE;
    w_alu = '0;
    if (w_upper_nz) begin
      w_dec.illegal = 1'b1;
    end else begin
      case (w_op4)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          w_dec.rf_wen  = 1'b1;
          w_dec.regdest = 1'b1;
          w_dec.s6      = 1'b1;
          w_alu         = ALUW'(w_op4[2:0]);
        end
        OP_SLL, OP_SRL, OP_SRA, OP_RL: begin
          w_dec.rf_wen  = 1'b1;
          w_dec.regdest = 1'b1;
          w_dec.s6      = 1'b1;
          w_dec.alusrc  = 1'b1;
          w_alu         = ALUW'(w_op4[2:0]);
        end
        OP_LW: begin
          w_dec.rf_wen  = 1'b1;
          w_dec.alusrc  = 1'b1;
          w_dec.regdest = 1'b1;
          w_dec.mem2reg = 1'b1;
          w_dec.s6      = 1'b1;
          w_dec.lw      = 1'b1;
        end
        OP_SW: begin
          w_dec.dmem_wen     = 1'b0;
          w_dec.alusrc       = 1'b1;
          w_dec.lhb_llb_con1 = 1'b1;
          w_dec.s6           = 1'b1;
        end
        OP_LHB: begin
          w_dec.rf_wen       = 1'b1;
          w_dec.regdest      = 1'b1;
          w_dec.lhb_llb_con1 = 1'b1;
          w_dec.s5           = 1'b1;
          w_alu              = ALUW'(3'b010);
        end
        OP_LLB: begin
          w_dec.rf_wen  = 1'b1;
          w_dec.regdest = 1'b1;
          w_dec.s7      = 1'b1;
        end
        OP_BR: begin
          w_dec.branch       = 1'b1;
          w_dec.branch_taken = w_taken;
        end
        OP_JAL: begin
          w_dec.rf_wen = 1'b1;
          w_dec.jal    = 1'b1;
          w_dec.s6     = 1'b1;
        end
        OP_JR: begin
          w_dec.lhb_llb_con1 = 1'b1;
          w_dec.s6           = 1'b1;
          w_dec.jr           = 1'b1;
        end
        OP_EXEC: begin
          w_dec.lhb_llb_con1 = 1'b1;
          w_dec.s6           = 1'b1;
          w_dec.exec         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Issue FSM next state: flush forces RUN, stall freezes state and counter
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (flush) begin
      w_state_n = ST_RUN;
      w_cnt_n   = 3'd0;
    end else if (!stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_is_exec) begin
            w_state_n = ST_EXEC_HOLD;
            w_cnt_n   = 3'(EXEC_BUBBLES);
          end
        end
        ST_EXEC_HOLD: begin
          w_cnt_n = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_state_n = ST_RUN;
            w_cnt_n   = 3'd0;
          end
        end
        default: begin
          w_state_n = ST_RUN;
          w_cnt_n   = 3'd0;
        end
      endcase
    end
  end

  // Issue FSM state and bubble counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Flag register loads whenever flag_wen is high, regardless of stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (flag_wen) begin
      r_flags <= flag_in;
    end
  end

  // Output register: flush clears, stall holds, otherwise load decode or bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_bundle    <= CTRL_BUBBLE;
      r_alu       <= '0;
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_bundle    <= w_dec;
        r_alu       <= w_alu;
        r_out_valid <= 1'b1;
      end else begin
        r_bundle    <= CTRL_BUBBLE;
        r_alu       <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign dmem_wen     = r_bundle.dmem_wen;
  assign rf_wen       = r_bundle.rf_wen;
  assign alusrc       = r_bundle.alusrc;
  assign regdest      = r_bundle.regdest;
  assign branch       = r_bundle.branch;
  assign branch_taken = r_bundle.branch_taken;
  assign mem2reg      = r_bundle.mem2reg;
  assign lhb_llb_con1 = r_bundle.lhb_llb_con1;
  assign s5           = r_bundle.s5;
  assign s6           = r_bundle.s6;
  assign s7           = r_bundle.s7;
  assign jal          = r_bundle.jal;
  assign jr           = r_bundle.jr;
  assign exec         = r_bundle.exec;
  assign lw           = r_bundle.lw;
  assign illegal      = r_bundle.illegal;
  assign alu_op       = r_alu;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed walk through the decoder's main scenarios
// followed by a randomized run, all checked against a behavioural model.
// Instantiated with OPW=5 (so illegal opcodes exist) and EXEC_BUBBLES=2.
module tb_ctrl_decode_pipe;

  localparam int OPW   = 5;
  localparam int CONDW = 3;
  localparam int ALUW  = 3;
  localparam int BUB   = 2;

  // Packed view of the control outputs:
  // {dmem_wen,rf_wen,alusrc,regdest,branch,branch_taken,mem2reg,lhb_llb_con1,
  //  s5,s6,s7,jal,jr,exec,lw,illegal,alu_op[2:0]}
  localparam int B_DMEM = 18, B_RF = 17, B_ASRC = 16, B_RDST = 15, B_BR = 14;
  localparam int B_BT = 13, B_M2R = 12, B_LHB = 11, B_S5 = 10, B_S6 = 9;
  localparam int B_S7 = 8, B_JAL = 7, B_JR = 6, B_EXEC = 5, B_LW = 4, B_ILL = 3;
  localparam logic [18:0] BUB_V = 19'h40000;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OPW-1:0]   opcode = '0;
  logic [CONDW-1:0] cond = '0;
  logic [2:0]       flag_in = '0;
  logic             flag_wen = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid, dmem_wen, rf_wen, alusrc, regdest, branch;
  logic             branch_taken, mem2reg, lhb_llb_con1, s5, s6, s7;
  logic             jal, jr, exec, lw, illegal, o_dbg_state;
  logic [ALUW-1:0]  alu_op;
  logic [18:0]      w_act;

  assign w_act = {dmem_wen, rf_wen, alusrc, regdest, branch, branch_taken,
                  mem2reg, lhb_llb_con1, s5, s6, s7, jal, jr, exec, lw,
                  illegal, alu_op};

  ctrl_decode_pipe #(
    .OPW(OPW), .CONDW(CONDW), .ALUW(ALUW), .EXEC_BUBBLES(BUB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .cond(cond), .flag_in(flag_in), .flag_wen(flag_wen),
    .stall(stall), .flush(flush), .out_valid(out_valid),
    .dmem_wen(dmem_wen), .rf_wen(rf_wen), .alusrc(alusrc),
    .regdest(regdest), .branch(branch), .branch_taken(branch_taken),
    .mem2reg(mem2reg), .lhb_llb_con1(lhb_llb_con1), .s5(s5), .s6(s6),
    .s7(s7), .jal(jal), .jr(jr), .exec(exec), .lw(lw), .alu_op(alu_op),
    .illegal(illegal), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] exp_q[$];
  logic        m_ov = 1'b0;
  logic [18:0] m_ctrl = BUB_V;
  logic [2:0]  m_flags = 3'b000;
  int          m_hold = 0;   // issue bubbles still owed after an EXEC
  logic        exp_bt;

  // Branch condition truth from the {Z,V,N} flags
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Expected control outputs for one accepted instruction
  function automatic logic [18:0] exp_ctrl(input logic [4:0] op,
                                           input logic [2:0] c,
                                           input logic [2:0] f);
    logic [18:0] v;
    v = BUB_V;
    if (op[4]) begin
      v[B_ILL] = 1'b1;
    end else if (op < 5'd8) begin
      v[B_RF] = 1'b1; v[B_RDST] = 1'b1; v[B_S6] = 1'b1;
      v[B_ASRC] = (op >= 5'd4);
      v[2:0] = op[2:0];
    end else begin
      case (op)
        5'd8:  begin v[B_RF] = 1; v[B_ASRC] = 1; v[B_RDST] = 1; v[B_M2R] = 1; v[B_S6] = 1; v[B_LW] = 1; end
        5'd9:  begin v[B_DMEM] = 0; v[B_ASRC] = 1; v[B_LHB] = 1; v[B_S6] = 1; end
        5'd10: begin v[B_RF] = 1; v[B_RDST] = 1; v[B_LHB] = 1; v[B_S5] = 1; v[2:0] = 3'b010; end
        5'd11: begin v[B_RF] = 1; v[B_RDST] = 1; v[B_S7] = 1; end
        5'd12: begin v[B_BR] = 1; v[B_BT] = cond_true(c, f); end
        5'd13: begin v[B_RF] = 1; v[B_JAL] = 1; v[B_S6] = 1; end
        5'd14: begin v[B_LHB] = 1; v[B_S6] = 1; v[B_JR] = 1; end
        default: begin v[B_LHB] = 1; v[B_S6] = 1; v[B_EXEC] = 1; end
      endcase
    end
    return v;
  endfunction

  // One comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock with model update and checks ----------------
  // Inputs are already set by the caller; they are sampled on the next posedge.
  task automatic step(input string tag);
    logic       rdy, acc;
    logic [2:0] fe;
    #1;
    rdy = !rst && !stall && (m_hold == 0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    check({tag, "_state"}, {31'd0, o_dbg_state}, {31'd0, (m_hold != 0)});
    acc = in_valid && rdy;
    fe  = m_flags;
`ifdef CTRL_FLAG_BYPASS_EN
    if (flag_wen) fe = flag_in;
`endif
    if (rst) begin
      m_ov = 1'b0; m_ctrl = BUB_V; m_flags = 3'b000; m_hold = 0;
    end else begin
      if (flush) begin
        m_ov = 1'b0; m_ctrl = BUB_V; m_hold = 0;
      end else if (!stall) begin
        if (m_hold > 0) m_hold--;
        if (acc) begin
          m_ov = 1'b1;
          m_ctrl = exp_ctrl(opcode, cond, fe);
          if (opcode == 5'h0F) m_hold = BUB;
        end else begin
          m_ov = 1'b0; m_ctrl = BUB_V;
        end
      end
      if (flag_wen) m_flags = flag_in;
    end
    exp_q.push_back(m_ctrl);
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
    check({tag, "_ctrl"}, {13'd0, w_act}, {13'd0, exp_q.pop_front()});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    rst = 1'b1;
    step("rst0");
    step("rst1");
    check("rst_dmem_wen", {31'd0, dmem_wen}, 32'd1);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst = 1'b0;

    // ADD accepted
    in_valid = 1'b1; opcode = 5'h00; cond = 3'd0;
    step("add");
    check("add_rf_wen", {31'd0, rf_wen}, 32'd1);
    check("add_s6", {31'd0, s6}, 32'd1);

    // Z flag set, then branches on EQ / NE
    in_valid = 1'b0; flag_wen = 1'b1; flag_in = 3'b100;
    step("flagz");
    flag_wen = 1'b0; in_valid = 1'b1; opcode = 5'h0C; cond = 3'd0;
    step("br_eq");
    check("br_eq_taken", {31'd0, branch_taken}, 32'd1);
    cond = 3'd1;
    step("br_ne");
    check("br_ne_taken", {31'd0, branch_taken}, 32'd0);
    check("br_ne_branch", {31'd0, branch}, 32'd1);

    // EXEC followed by two bubble cycles, ADD waiting at the input
    opcode = 5'h0F;
    step("exec");
    check("exec_bit", {31'd0, exec}, 32'd1);
    opcode = 5'h00;
    step("hold1");
    check("hold1_out_valid", {31'd0, out_valid}, 32'd0);
    step("hold2");
    step("add2");
    check("add2_out_valid", {31'd0, out_valid}, 32'd1);

    // SW then a 3-cycle stall
    opcode = 5'h09;
    step("sw");
    check("sw_dmem_wen", {31'd0, dmem_wen}, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("sw_stall");
      check("sw_stall_dmem_wen", {31'd0, dmem_wen}, 32'd0);
    end
    stall = 1'b0; in_valid = 1'b0;
    step("unstall");

    // LW pending, then flush together with stall
    in_valid = 1'b1; opcode = 5'h08;
    step("lw");
    check("lw_mem2reg", {31'd0, mem2reg}, 32'd1);
    stall = 1'b1; flush = 1'b1;
    step("flush");
    check("flush_lw", {31'd0, lw}, 32'd0);
    check("flush_mem2reg", {31'd0, mem2reg}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Same-cycle flag write and branch LT
    in_valid = 1'b0; flag_wen = 1'b1; flag_in = 3'b000;
    step("flag0");
    in_valid = 1'b1; opcode = 5'h0C; cond = 3'd3; flag_in = 3'b001;
    step("bypass");
`ifdef CTRL_FLAG_BYPASS_EN
    exp_bt = 1'b1;
`else
    exp_bt = 1'b0;
`endif
    check("bypass_taken", {31'd0, branch_taken}, {31'd0, exp_bt});
    flag_wen = 1'b0;

    // Illegal opcode with EXEC low bits must not start a hold
    opcode = 5'h1F;
    step("illegal");
    check("illegal_bit", {31'd0, illegal}, 32'd1);
    check("illegal_exec", {31'd0, exec}, 32'd0);
    in_valid = 1'b0;
    step("after_illegal");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      flag_wen = ($urandom_range(0, 2) == 0);
      flag_in  = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      opcode   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31))
                                             : 5'($urandom_range(0, 15));
      cond     = 3'($urandom_range(0, 7));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
